// File: rtl/ysyx_20020207_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ifu_state_e   : fetch FSM states (IDLE, ADDR, DATA, HOLD), 2-bit encoding
//   AXI_RESP_OKAY : AXI read response value meaning success
//   INST_WIDTH    : width of one instruction word
package ysyx_20020207_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_ADDR = 2'd1,
        IFU_DATA = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam int unsigned INST_WIDTH    = 32;

endpackage

// File: rtl/ysyx_20020207_ifu.sv
// Instruction fetch unit: latches the PC on a pc_ready pulse, performs one
// AXI4-Lite read for the instruction word and holds the result until decode
// accepts it. One outstanding fetch, no prefetch, no cache.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   pc, pc_ready              PC from the PC register and its one-cycle strobe
//   araddr/arvalid/arready    AXI read address channel
//   rdata/rresp/rvalid/rready AXI read data channel
//   inst, inst_pc, inst_fault fetched word, its PC, access-fault flag
//   inst_valid, inst_ready    handshake towards decode
//   busy                      FSM not IDLE
//   overrun                   sticky: pc_ready seen while not IDLE
module ysyx_20020207_ifu
    import ysyx_20020207_ifu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  pc_ready,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  inst_fault,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  busy,
    output logic                  overrun
);

    ifu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] araddr_q, araddr_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [DATA_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  inst_fault_q, inst_fault_d;
    logic                  overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        // Any strobe outside IDLE is dropped, including one coinciding with
        // the HOLD->IDLE handshake, since the decision is made on state_q.
        overrun_d    = overrun_q | (pc_ready && (state_q != IFU_IDLE));

        unique case (state_q)
            IFU_IDLE: begin
                if (pc_ready) begin
                    inst_pc_d = pc;
                    if (pc[1:0] == 2'b00) begin
                        araddr_d = pc;
                        state_d  = IFU_ADDR;
                    end else begin
                        // Misaligned: report a fault without touching the bus.
                        inst_d       = '0;
                        inst_fault_d = 1'b1;
                        state_d      = IFU_HOLD;
                    end
                end
            end
            IFU_ADDR: begin
                if (arready) begin
                    state_d = IFU_DATA;
                end
            end
            IFU_DATA: begin
                if (rvalid) begin
                    inst_d       = rdata[INST_WIDTH-1:0];
                    inst_fault_d = (rresp != AXI_RESP_OKAY);
                    state_d      = IFU_HOLD;
                end
            end
            IFU_HOLD: begin
                if (inst_ready) begin
                    state_d = IFU_IDLE;
                end
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IFU_IDLE;
            araddr_q     <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
            overrun_q    <= overrun_d;
        end
    end

    // Handshake outputs are pure state decodes: no input-to-output paths.
    assign arvalid    = (state_q == IFU_ADDR);
    assign rready     = (state_q == IFU_DATA);
    assign inst_valid = (state_q == IFU_HOLD);
    assign busy       = (state_q != IFU_IDLE);

    assign araddr     = araddr_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/ysyx_20020207_ifu.md
# ysyx_20020207_ifu

Instruction fetch unit for the 32-bit multi-cycle core. Sits directly downstream of the PC register. It latches the PC on each `pc_ready` pulse, issues a single AXI4-Lite read for the instruction word, and holds the fetched word in an output register until the decode stage accepts it through a valid/ready handshake. It supports one outstanding fetch, with no prefetch and no cache.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of PC, address and instruction data.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-low: `rst==0` at a rising edge resets the block.
- `pc`  in  DATA_WIDTH  current PC; sampled only when `pc_ready==1`.
- `pc_ready`  in  1  one-cycle pulse from the PC register: new PC is valid.
- `araddr`  out  DATA_WIDTH  AXI read address.
- `arvalid`  out  1  AXI read address valid.
- `arready`  in  1  AXI read address ready.
- `rdata`  in  DATA_WIDTH  AXI read data.
- `rresp`  in  2  AXI read response (2'b00 = OKAY).
- `rvalid`  in  1  AXI read data valid.
- `rready`  out  1  AXI read data ready.
- `inst`  out  32  fetched instruction.
- `inst_pc`  out  DATA_WIDTH  PC of `inst`.
- `inst_fault`  out  1  fetch faulted (misaligned PC or non-OKAY `rresp`).
- `inst_valid`  out  1  `inst`/`inst_pc`/`inst_fault` valid.
- `inst_ready`  in  1  decode accepts the instruction.
- `busy`  out  1  FSM not IDLE.
- `overrun`  out  1  sticky: `pc_ready` arrived while busy.

## Operation
- FSM states and transitions:
  - IDLE:
    - `pc_ready` with `pc[1:0]==0` → ADDR; latch `pc` into the address and `inst_pc` registers.
    - `pc_ready` with `pc[1:0]!=0` → HOLD; `inst`=0, `inst_fault`=1, no bus transaction.
  - ADDR: `arvalid`=1, `araddr` = latched PC, held stable until handshake. `arvalid && arready` → DATA.
  - DATA: `rready`=1. `rvalid && rready` → HOLD; capture `inst`=`rdata[31:0]` and `inst_fault`=(`rresp`!=2'b00).
  - HOLD: `inst_valid`=1; outputs stable. `inst_valid && inst_ready` → IDLE.
- Output decode:
  - `arvalid`, `rready`, `inst_valid` and `busy` are registered or pure state decodes; no combinational path from inputs to outputs.
  - `busy` = (state != IDLE).
- `pc_ready` in any state other than IDLE is ignored: the latched PC is unchanged, the transaction continues, and `overrun` is set to 1 until reset.
- `pc_ready` in the same cycle as the HOLD→IDLE handshake is also an overrun; the PC stage must not pulse before decode consumes.
- On a faulted fetch, `inst` = `rdata` as received; decode treats `inst_fault` as an instruction access fault.
- Reset values: state=IDLE, `arvalid`=0, `rready`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `inst_fault`=0, `araddr`=0, `overrun`=0, `busy`=0.
- Reset mid-transaction abandons it immediately. The bus slave is reset by the same signal, so no drain is required.

## Timing
- `pc_ready` at cycle N → `arvalid`=1 at N+1.
- `arready`=1 at N+1 → `rready`=1 at N+2.
- `rvalid`=1 at N+2 → `inst_valid`=1 at N+3. Minimum fetch latency is 3 cycles.
- Misaligned PC: `inst_valid`=1 at N+1, and `arvalid` stays 0 throughout.
- Bus stalls:
  - `arready`/`rvalid` low stretch ADDR/DATA indefinitely.
  - While stalled, `araddr`/`arvalid` must not change.
- Decode stall: `inst_ready` low holds HOLD indefinitely, with all `inst*` outputs stable.
- `inst_ready` high at N+3 → `inst_valid`=0 and `busy`=0 at N+4.

## Structure
- Shared package holds:
  - the IFU state enum: IDLE, ADDR, DATA, HOLD (2-bit);
  - `AXI_RESP_OKAY` = 2'b00;
  - `INST_WIDTH` = 32.
- Single flat module with one FSM plus output registers; no sub-module is warranted. The AXI read channel logic is too small to split out.
- Top level wires:
  - PC `pc` / `pc_ready` → IFU `pc` / `pc_ready`;
  - IFU AXI read channel → the core's memory arbiter.

## Test plan
- Zero-wait fetch: pulse `pc_ready` with `pc`=32'h8000_0000; slave answers `arready` at N+1 and `rvalid` at N+2 with `rdata`=32'h0000_0413, OKAY → `araddr`=32'h8000_0000, `inst_valid` at N+3, `inst`=32'h0000_0413, `inst_pc`=32'h8000_0000, `inst_fault`=0.
- Bus and decode stalls: `arready` delayed 4 cycles, `rvalid` delayed 3, `inst_ready` low for 5 cycles → `araddr` and `inst` stable throughout, with exactly one AR and one R handshake.
- Error response: `rresp`=2'b10 with `pc`=32'h3000_0004 → `inst_fault`=1, `inst_pc`=32'h3000_0004.
- Misaligned PC: `pc`=32'h8000_0002 → no `arvalid`; `inst_valid` at N+1 with `inst_fault`=1, `inst`=0.
- Overrun: second `pc_ready` (`pc`=32'h8000_0008) while in DATA → `overrun`=1 and sticky; delivered `inst_pc` is still the first PC.
- Reset mid-fetch: `rst`=0 during DATA → next cycle state IDLE, `rready`=0, `inst_valid`=0, `overrun`=0; a new fetch after reset completes normally.
